// File: rtl/ets_frame_averager.sv
// Averages 2^log2_avg consecutive AXI-Stream frames point-by-point in an
// accumulator RAM, then streams out one averaged frame per run.
module ets_frame_averager #(
    parameter int DATA_WIDTH   = 32,
    parameter int ACC_WIDTH    = 40,
    parameter int ADDR_WIDTH   = 10,
    parameter int MAX_LOG2_AVG = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            log2_avg,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_len_err,
    output logic [ADDR_WIDTH:0]   frame_len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);
    localparam int MAX_LEN = 2 ** ADDR_WIDTH;
    localparam int CNT_W   = MAX_LOG2_AVG + 1;

    localparam logic [3:0]            MAX_L2 = 4'(MAX_LOG2_AVG);
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = 1;
    localparam logic [ADDR_WIDTH:0]   ONE_L  = 1;
    localparam logic [CNT_W-1:0]      ONE_C  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH,
        ST_DRAIN,
        ST_FIN
    } state_t;

    state_t state, state_nx;

    // run control
    logic [3:0]            log2_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic [CNT_W-1:0]      frame_cnt;
    logic [CNT_W-1:0]      frame_target;
    logic [ADDR_WIDTH:0]   last_idx;
    logic                  first_frame;
    logic                  beat;
    logic                  at_last_idx;
    logic                  len_err;
    logic                  run_complete;
    logic                  accept_start;

    // accumulator RAM and read-modify-write pipeline
    logic [ACC_WIDTH-1:0]  acc_mem [MAX_LEN];
    logic [ACC_WIDTH-1:0]  rd_q;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ACC_WIDTH-1:0]  wr_data;
    logic                  rmw_beat;
    logic                  p1_valid;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_data;
    logic                  fwd_hit;
    logic [ACC_WIDTH-1:0]  fwd_data;
    logic [ACC_WIDTH-1:0]  operand;
    logic [ACC_WIDTH-1:0]  sum;

    // drain path and 2-entry output buffer
    logic [ADDR_WIDTH-1:0] dr_addr;
    logic                  dr_all;
    logic                  dr_last_addr;
    logic                  rd_pend;
    logic                  rd_pend_last;
    logic [1:0]            occ;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] ob_data [2];
    logic                  ob_last [2];
    logic                  ob_wp;
    logic                  ob_rp;
    logic [1:0]            ob_cnt;

    always_comb begin
        accept_start = (state == ST_IDLE) && start;
        first_frame  = (frame_cnt == '0);
        beat         = (state == ST_ACCUM) && s_axis_tvalid;
        frame_target = {{(CNT_W-1){1'b0}}, 1'b1} << log2_q;
        last_idx     = frame_len - ONE_L;
        at_last_idx  = ({1'b0, idx} == last_idx);
        if (first_frame)
            len_err = beat && !s_axis_tlast && (idx == '1);
        else
            len_err = beat && (s_axis_tlast != at_last_idx);
        run_complete = beat && !len_err && s_axis_tlast &&
                       ((frame_cnt + ONE_C) == frame_target);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_ACCUM;
            ST_ACCUM: begin
                if (len_err)
                    state_nx = ST_FIN;
                else if (run_complete)
                    state_nx = ST_FLUSH;
            end
            ST_FLUSH: state_nx = ST_DRAIN;
            ST_DRAIN: if (pop && m_axis_tlast) state_nx = ST_FIN;
            ST_FIN:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != ST_IDLE);
        done          = (state == ST_FIN);
        s_axis_tready = (state == ST_ACCUM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            log2_q        <= '0;
            idx           <= '0;
            frame_cnt     <= '0;
            frame_len     <= '0;
            frame_len_err <= 1'b0;
        end else if (accept_start) begin
            log2_q        <= (log2_avg > MAX_L2) ? MAX_L2 : log2_avg;
            idx           <= '0;
            frame_cnt     <= '0;
            frame_len_err <= 1'b0;
        end else if (beat) begin
            if (len_err) begin
                frame_len_err <= 1'b1;
            end else if (s_axis_tlast) begin
                idx       <= '0;
                frame_cnt <= frame_cnt + ONE_C;
                if (first_frame)
                    frame_len <= {1'b0, idx} + ONE_L;
            end else begin
                idx <= idx + ONE_A;
            end
        end
    end

    // A beat whose read coincides with the in-flight write to the same word
    // (only possible for L=1) takes the pending sum instead of stale RAM data.
    always_comb begin
        rmw_beat = beat && !first_frame && !len_err;
        operand  = fwd_hit ? fwd_data : rd_q;
        sum      = operand + ACC_WIDTH'(p1_data);
        rd_addr  = (state == ST_DRAIN) ? dr_addr : idx;
        if (p1_valid) begin
            wr_en   = 1'b1;
            wr_addr = p1_addr;
            wr_data = sum;
        end else begin
            wr_en   = beat && first_frame && !len_err;
            wr_addr = idx;
            wr_data = ACC_WIDTH'(s_axis_tdata);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            acc_mem[wr_addr] <= wr_data;
        rd_q <= acc_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_valid <= 1'b0;
            p1_addr  <= '0;
            p1_data  <= '0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            p1_valid <= rmw_beat;
            p1_addr  <= idx;
            p1_data  <= s_axis_tdata;
            fwd_hit  <= rmw_beat && p1_valid && (idx == p1_addr);
            fwd_data <= sum;
        end
    end

    // Reads are issued only when the buffer can take the word one cycle later,
    // counting the read already in flight and a pop happening this cycle.
    always_comb begin
        m_axis_tvalid = (ob_cnt != 2'd0);
        m_axis_tdata  = ob_data[ob_rp];
        m_axis_tlast  = m_axis_tvalid && ob_last[ob_rp];
        pop           = m_axis_tvalid && m_axis_tready;
        push          = rd_pend;
        push_data     = DATA_WIDTH'(rd_q >> log2_q);
        dr_last_addr  = ({1'b0, dr_addr} == last_idx);
        occ           = ob_cnt + {1'b0, rd_pend};
        issue         = (state == ST_DRAIN) && !dr_all &&
                        ((occ < 2'd2) || ((occ == 2'd2) && pop));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dr_addr      <= '0;
            dr_all       <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            ob_wp        <= 1'b0;
            ob_rp        <= 1'b0;
            ob_cnt       <= '0;
            ob_data[0]   <= '0;
            ob_data[1]   <= '0;
            ob_last[0]   <= 1'b0;
            ob_last[1]   <= 1'b0;
        end else if (state != ST_DRAIN) begin
            dr_addr <= '0;
            dr_all  <= 1'b0;
            rd_pend <= 1'b0;
            ob_wp   <= 1'b0;
            ob_rp   <= 1'b0;
            ob_cnt  <= '0;
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= dr_last_addr;
            if (issue) begin
                dr_addr <= dr_addr + ONE_A;
                if (dr_last_addr)
                    dr_all <= 1'b1;
            end
            if (push) begin
                ob_data[ob_wp] <= push_data;
                ob_last[ob_wp] <= rd_pend_last;
                ob_wp          <= ~ob_wp;
            end
            if (pop)
                ob_rp <= ~ob_rp;
            case ({push, pop})
                2'b10:   ob_cnt <= ob_cnt + 2'd1;
                2'b01:   ob_cnt <= ob_cnt - 2'd1;
                default: ob_cnt <= ob_cnt;
            endcase
        end
    end

endmodule
